// File: rtl/alu_operand_core.sv
// Registered single-cycle ALU with 4:1 operand muxes on both inputs.
// Build option: define ALU_OPERAND_CORE_SHIFT_EN to include the SLL/SRL shifter.
module alu_operand_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in0,
    input  logic [WIDTH-1:0] a_in1,
    input  logic [WIDTH-1:0] a_in2,
    input  logic [WIDTH-1:0] a_in3,
    input  logic [WIDTH-1:0] b_in0,
    input  logic [WIDTH-1:0] b_in1,
    input  logic [WIDTH-1:0] b_in2,
    input  logic [WIDTH-1:0] b_in3,
    input  logic [1:0]       a_sel,
    input  logic [1:0]       b_sel,
    input  logic [2:0]       alu_op,
    input  logic             valid_in,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             pos,
    output logic             carry,
    output logic             valid_out
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

`ifdef ALU_OPERAND_CORE_SHIFT_EN
    localparam int unsigned SHW = $clog2(WIDTH);
`endif

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             res_zero;
    logic             res_pos;

    // Operand A select
    always_comb begin
        op_a = a_in0;
        case (a_sel)
            2'd0:    op_a = a_in0;
            2'd1:    op_a = a_in1;
            2'd2:    op_a = a_in2;
            default: op_a = a_in3;
        endcase
    end

    // Operand B select
    always_comb begin
        op_b = b_in0;
        case (b_sel)
            2'd0:    op_b = b_in0;
            2'd1:    op_b = b_in1;
            2'd2:    op_b = b_in2;
            default: op_b = b_in3;
        endcase
    end

    // Extended add/sub: the top bit is carry-out for ADD and borrow for SUB
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

    // Operation decode
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
`ifdef ALU_OPERAND_CORE_SHIFT_EN
            OP_SLL:  alu_res = op_a << op_b[SHW-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SHW-1:0];
`else
            OP_SLL:  alu_res = op_a;
            OP_SRL:  alu_res = op_a;
`endif
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign res_zero = (alu_res == '0);
    assign res_pos  = ~alu_res[WIDTH-1] & ~res_zero;

    // Result and flags load only on a valid request; otherwise they hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            zero   <= 1'b1;
            pos    <= 1'b0;
            carry  <= 1'b0;
        end else if (valid_in) begin
            result <= alu_res;
            zero   <= res_zero;
            pos    <= res_pos;
            carry  <= alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
        end
    end

endmodule

// File: tb/tb_alu_operand_core.sv
// Self-checking bench for alu_operand_core: directed table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_alu_operand_core;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] ain [4];
    logic [WIDTH-1:0] bin [4];
    logic [1:0]       a_sel;
    logic [1:0]       b_sel;
    logic [2:0]       alu_op;
    logic             valid_in;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             pos;
    logic             carry;
    logic             valid_out;

    int checks   = 0;
    int failures = 0;

    alu_operand_core #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in0    (ain[0]),
        .a_in1    (ain[1]),
        .a_in2    (ain[2]),
        .a_in3    (ain[3]),
        .b_in0    (bin[0]),
        .b_in1    (bin[1]),
        .b_in2    (bin[2]),
        .b_in3    (bin[3]),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .alu_op   (alu_op),
        .valid_in (valid_in),
        .result   (result),
        .zero     (zero),
        .pos      (pos),
        .carry    (carry),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       asel;
        logic [1:0]       bsel;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_res;
        logic             exp_z;
        logic             exp_p;
        logic             exp_c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [WIDTH-1:0] r, input logic z,
                             input logic p, input logic c, input logic v);
        check({name, ".result"}, 32'(result), 32'(r));
        check({name, ".zero"}, 32'(zero), 32'(z));
        check({name, ".pos"}, 32'(pos), 32'(p));
        check({name, ".carry"}, 32'(carry), 32'(c));
        check({name, ".valid_out"}, 32'(valid_out), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            ain[i] = WIDTH'($urandom);
            bin[i] = WIDTH'($urandom);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned operands
    task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] r, output logic c);
        longint ua;
        longint ub;
        longint m;
        longint v;
        ua = longint'(a);
        ub = longint'(b);
        m  = longint'(1) << WIDTH;
        c  = 1'b0;
        v  = 0;
        case (op)
            3'd0: begin v = ua + ub; c = (v >= m); end
            3'd1: begin v = ua - ub + m; c = (ua >= ub); end
            3'd2: v = longint'(a & b);
            3'd3: v = longint'(a | b);
            3'd4: v = longint'(a ^ b);
`ifdef ALU_OPERAND_CORE_SHIFT_EN
            3'd5: v = ua * (longint'(1) << (ub % 16));
            3'd6: v = ua / (longint'(1) << (ub % 16));
`else
            3'd5: v = ua;
            3'd6: v = ua;
`endif
            default: v = ub;
        endcase
        r = WIDTH'(v % m);
    endtask

    vec_t             vecs [12];
    logic [WIDTH-1:0] mr;
    logic             mc;
    logic [WIDTH-1:0] hold_r;
    logic             hold_z;
    logic             hold_p;
    logic             hold_c;

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        valid_in = 1'b0;
        a_sel    = '0;
        b_sel    = '0;
        alu_op   = '0;
        randomize_inputs();

        // Reset held: activity on inputs must not disturb outputs
        valid_in = 1'b1;
        alu_op   = 3'd0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step();
            check_out("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        valid_in = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Operand A mux sweep, back-to-back valid
        ain[0] = 16'h0001; ain[1] = 16'h0010; ain[2] = 16'h0100; ain[3] = 16'h1000;
        for (int i = 0; i < 4; i++) bin[i] = '0;
        alu_op   = 3'd0;
        b_sel    = 2'd0;
        valid_in = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            step();
            check_out($sformatf("mux_a%0d", s), ain[s], 1'b0, 1'b1, 1'b0, 1'b1);
        end

        // Directed table, applied back-to-back
        vecs[0]  = '{2'd0, 2'd1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{2'd1, 2'd2, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 2'd3, 3'd1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{2'd3, 2'd0, 3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 2'd2, 3'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 2'd3, 3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'd2, 2'd1, 3'd7, 16'h1234, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0};
`ifdef ALU_OPERAND_CORE_SHIFT_EN
        vecs[7]  = '{2'd3, 2'd0, 3'd5, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'd0, 2'd3, 3'd6, 16'h8001, 16'h0004, 16'h0800, 1'b0, 1'b1, 1'b0};
`else
        vecs[7]  = '{2'd3, 2'd0, 3'd5, 16'h8001, 16'h0004, 16'h8001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 2'd3, 3'd6, 16'h8001, 16'h0004, 16'h8001, 1'b0, 1'b0, 1'b0};
`endif
        vecs[9]  = '{2'd1, 2'd1, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'd2, 2'd0, 3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2'd3, 2'd2, 3'd5, 16'h0003, 16'hFFF0, 16'h0003, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            randomize_inputs();
            ain[vecs[i].asel] = vecs[i].a;
            bin[vecs[i].bsel] = vecs[i].b;
            a_sel    = vecs[i].asel;
            b_sel    = vecs[i].bsel;
            alu_op   = vecs[i].op;
            valid_in = 1'b1;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_z,
                      vecs[i].exp_p, vecs[i].exp_c, 1'b1);
        end

        // Hold: one SUB then three idle cycles with changing inputs
        randomize_inputs();
        ain[1] = 16'h0005; bin[2] = 16'h0003;
        a_sel = 2'd1; b_sel = 2'd2; alu_op = 3'd1; valid_in = 1'b1;
        step();
        check_out("hold_load", 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1);
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            alu_op = 3'(i);
            step();
            check_out($sformatf("hold%0d", i), 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Mid-op reset: pulse between edges, then idle
        ain[0] = 16'h00F0; bin[0] = 16'h000F;
        a_sel = 2'd0; b_sel = 2'd0; alu_op = 3'd0; valid_in = 1'b1;
        step();
        check_out("midrst_pre", 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_out("midrst_async", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        valid_in = 1'b0;
        step();
        check_out("midrst_after", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        hold_r = '0; hold_z = 1'b1; hold_p = 1'b0; hold_c = 1'b0;
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            a_sel    = 2'($urandom);
            b_sel    = 2'($urandom);
            alu_op   = 3'($urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            if (valid_in) begin
                model(alu_op, ain[a_sel], bin[b_sel], mr, mc);
                hold_r = mr;
                hold_c = mc;
                hold_z = (mr == 0);
                hold_p = (mr != 0) && (mr < 16'h8000);
            end
            step();
            check_out($sformatf("rand%0d", i), hold_r, hold_z, hold_p, hold_c, valid_in);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_core.md
ALU_OPERAND_CORE -- requirements
Module: alu_operand_core

Interface
- REQ-001 SHALL have parameter: WIDTH, 16, datapath width in bits for all operand and result buses.
- REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
- REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- REQ-004 SHALL have ports: a_in0..a_in3  input  WIDTH each  candidate operands for ALU input 0.
- REQ-005 SHALL have ports: b_in0..b_in3  input  WIDTH each  candidate operands for ALU input 1.
- REQ-006 SHALL have port: a_sel  input  2  four-way select for operand A (0→a_in0 … 3→a_in3).
- REQ-007 SHALL have port: b_sel  input  2  four-way select for operand B (0→b_in0 … 3→b_in3).
- REQ-008 SHALL have port: alu_op  input  3  operation code.
- REQ-009 SHALL have port: valid_in  input  1  operation request this cycle.
- REQ-010 SHALL have port: result  output  WIDTH  registered ALU result.
- REQ-011 SHALL have ports: zero, pos, carry  output  1 each  registered flags.
- REQ-012 SHALL have port: valid_out  output  1  result/flags updated this cycle.

Function
- REQ-013 Operand muxes SHALL be purely combinational 4:1 selects; every a_sel/b_sel value SHALL select a defined input (no X, no latch).
- REQ-014 alu_op decoding SHALL be: 000 ADD A+B; 001 SUB A−B; 010 AND; 011 OR; 100 XOR; 101 SLL A<<B[3:0]; 110 SRL A>>B[3:0] (logical); 111 PASS B.
- REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; carry = carry-out of ADD, = NOT borrow for SUB (1 when A ≥ B unsigned); carry = 0 for all other ops.
- REQ-016 Shift amounts ≥ WIDTH cannot occur for WIDTH=16; shift-in bits SHALL be 0.
- REQ-017 zero SHALL be 1 iff the registered result equals 0.
- REQ-018 pos SHALL be 1 iff the result is signed strictly positive (MSB = 0 and result ≠ 0); zero and pos SHALL never both be 1.
- REQ-019 Latency SHALL be exactly one cycle: inputs sampled at edge N with valid_in=1 appear on result/flags after edge N, with valid_out=1 for that cycle.
- REQ-020 When valid_in=0 at an edge, result, zero, pos, carry SHALL hold previous values and valid_out SHALL be 0.
- REQ-021 Back-to-back valid_in=1 SHALL produce one result per cycle with no bubbles.

Reset
- REQ-022 While rst=0, result SHALL be 0, zero SHALL be 1, pos SHALL be 0, carry SHALL be 0, valid_out SHALL be 0, asynchronously, regardless of clk.
- REQ-023 Reset asserted mid-operation SHALL discard the in-flight operation; first valid_out after deassertion SHALL come only from an operation sampled after rst returns to 1.
- REQ-024 Reset SHALL affect only registers; the muxes are combinational and need no reset.

Configuration
- REQ-025 Macro ALU_OPERAND_CORE_SHIFT_EN SHALL control the shifter: defined → ops 101/110 behave per REQ-014; undefined → no shifter logic, ops 101/110 SHALL return operand A unchanged with carry = 0.

Verification
- REQ-026 Reset: hold rst=0, toggle clk, apply valid_in=1 → result=0x0000, zero=1, pos=0, carry=0, valid_out=0 throughout.
- REQ-027 Mux coverage: a_in0..3 = 0x0001/0x0010/0x0100/0x1000, b_in* = 0, alu_op=000, sweep a_sel 0..3 → result equals selected input one cycle later, pos=1.
- REQ-028 Arithmetic boundary: A=0xFFFF, B=0x0001, ADD → result=0x0000, zero=1, carry=1; A=0x0000, B=0x0001, SUB → result=0xFFFF, pos=0, carry=0.
- REQ-029 Hold: one valid op (A=0x0005, B=0x0003, SUB → 0x0002), then valid_in=0 for 3 cycles → result stays 0x0002, valid_out=0.
- REQ-030 Shift: A=0x8001, B=0x0004; SLL → 0x0010, SRL → 0x0800 with macro defined; 0x8001 for both with macro undefined.
- REQ-031 Mid-op reset: valid_in=1 at edge N, pulse rst=0 between edges N and N+1 → outputs at reset values, valid_out=0 after N+1 with valid_in=0.
